// File: rtl/alu_ops_pkg.sv
// Shared definitions for the ALU operand driver: opcode values understood by the
// external ALU and the sequencing FSM state encoding.
package alu_ops_pkg;

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] ROL     = 4'd0;
  localparam logic [OpW-1:0] ROR     = 4'd1;
  localparam logic [OpW-1:0] MAX     = 4'd2;
  localparam logic [OpW-1:0] MIN     = 4'd3;
  localparam logic [OpW-1:0] SGT     = 4'd4;
  // First opcode value the ALU does not implement.
  localparam logic [OpW-1:0] NUM_OPS = 4'd5;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request buffer with full/empty flags.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the buffer)
//   push_i, wdata_i   write strobe and data; ignored while full
//   pop_i             read strobe; ignored while empty
//   rdata_o           head entry (valid while !empty_o)
//   full_o, empty_o   occupancy flags
module alu_req_fifo
  import alu_ops_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= wdata_i;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_op_driver.sv
// Front end owning the operand/opcode interface of an external combinational ALU.
// Requests are buffered, issued one at a time, held stable for ALU_LATENCY cycles,
// and the sampled result/flags are returned with the caller's tag.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_*                              valid/ready request channel (opcode, operands, shift, tag)
//   alu_opcode/input1/input2/shiftValue  registered drive into the ALU
//   alu_result/carryFlag/zeroFlag/overFlowFlag  ALU outputs, sampled after settling
//   rsp_*                              valid/ready response channel
//   busy                               work buffered or in flight
module alu_op_driver
  import alu_ops_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SHIFT_W     = 5,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [OpW-1:0]     req_opcode,
  input  logic [WIDTH-1:0]   req_input1,
  input  logic [WIDTH-1:0]   req_input2,
  input  logic [SHIFT_W-1:0] req_shift,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [OpW-1:0]     alu_opcode,
  output logic [WIDTH-1:0]   alu_input1,
  output logic [WIDTH-1:0]   alu_input2,
  output logic [SHIFT_W-1:0] alu_shiftValue,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_carryFlag,
  input  logic               alu_zeroFlag,
  input  logic               alu_overFlowFlag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_carry,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_illegal,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               busy
);

  localparam int unsigned EntryW = OpW + 2 * WIDTH + SHIFT_W + TAG_W;
  localparam int unsigned CntW   = $clog2(ALU_LATENCY + 1);

  logic [EntryW-1:0]  fifo_rdata;
  logic               fifo_full, fifo_empty, fifo_pop;
  logic [OpW-1:0]     f_op;
  logic [WIDTH-1:0]   f_in1, f_in2;
  logic [SHIFT_W-1:0] f_shift, shift_norm;
  logic [TAG_W-1:0]   f_tag;
  logic               op_legal;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic [OpW-1:0]     alu_opcode_q;
  logic [WIDTH-1:0]   alu_input1_q, alu_input2_q;
  logic [SHIFT_W-1:0] alu_shift_q;
  logic               rsp_valid_q, rsp_carry_q, rsp_zero_q, rsp_overflow_q, rsp_illegal_q;
  logic [WIDTH-1:0]   rsp_result_q;
  logic [TAG_W-1:0]   rsp_tag_q;

  alu_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_valid),
    .wdata_i ({req_opcode, req_input1, req_input2, req_shift, req_tag}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {f_op, f_in1, f_in2, f_shift, f_tag} = fifo_rdata;
  assign op_legal  = (f_op < NUM_OPS);
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;
  assign req_ready = !fifo_full;
  assign busy      = !fifo_empty || (state_q != StIdle);

  // Rotates are taken modulo the operand width; other ops see the raw shift.
  always_comb begin
    shift_norm = f_shift;
    if (f_op == ROL || f_op == ROR) begin
      shift_norm = f_shift % SHIFT_W'(WIDTH);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      tag_q          <= '0;
      alu_opcode_q   <= '0;
      alu_input1_q   <= '0;
      alu_input2_q   <= '0;
      alu_shift_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
      rsp_tag_q      <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            if (op_legal) begin
              alu_opcode_q <= f_op;
              alu_input1_q <= f_in1;
              alu_input2_q <= f_in2;
              alu_shift_q  <= shift_norm;
              tag_q        <= f_tag;
              cnt_q        <= CntW'(ALU_LATENCY);
              state_q      <= StWait;
            end else begin
              // Illegal ops never reach the ALU; the previous drive is kept.
              rsp_result_q   <= '0;
              rsp_carry_q    <= 1'b0;
              rsp_zero_q     <= 1'b0;
              rsp_overflow_q <= 1'b0;
              rsp_illegal_q  <= 1'b1;
              rsp_tag_q      <= f_tag;
              rsp_valid_q    <= 1'b1;
              state_q        <= StResp;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            rsp_result_q   <= alu_result;
            rsp_carry_q    <= alu_carryFlag;
            rsp_zero_q     <= alu_zeroFlag;
            rsp_overflow_q <= alu_overFlowFlag;
            rsp_illegal_q  <= 1'b0;
            rsp_tag_q      <= tag_q;
            rsp_valid_q    <= 1'b1;
            state_q        <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign alu_opcode     = alu_opcode_q;
  assign alu_input1     = alu_input1_q;
  assign alu_input2     = alu_input2_q;
  assign alu_shiftValue = alu_shift_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_result     = rsp_result_q;
  assign rsp_carry      = rsp_carry_q;
  assign rsp_zero       = rsp_zero_q;
  assign rsp_overflow   = rsp_overflow_q;
  assign rsp_illegal    = rsp_illegal_q;
  assign rsp_tag        = rsp_tag_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: behavioural ALU, queue-based reference model with a
// per-cycle compare process, plus directed checks with literal expectations.
module tb_alu_op_driver;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid = 1'b0, req_ready;
  logic [3:0] req_opcode = '0;
  logic [7:0] req_input1 = '0, req_input2 = '0;
  logic [4:0] req_shift = '0;
  logic [3:0] req_tag = '0;
  logic [3:0] alu_opcode;
  logic [7:0] alu_input1, alu_input2, alu_result;
  logic [4:0] alu_shiftValue;
  logic       alu_carryFlag, alu_zeroFlag, alu_overFlowFlag;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_zero, rsp_overflow, rsp_illegal;
  logic [3:0] rsp_tag;
  logic       busy;
  logic [7:0] noise = '0;  // XORed onto the ALU result to expose the sampling cycle

  int total = 0;
  int bad = 0;
  int cyc = 0;

  alu_op_driver #(
    .WIDTH       (8),
    .SHIFT_W     (5),
    .TAG_W       (4),
    .FIFO_DEPTH  (4),
    .ALU_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_opcode       (req_opcode),
    .req_input1       (req_input1),
    .req_input2       (req_input2),
    .req_shift        (req_shift),
    .req_tag          (req_tag),
    .alu_opcode       (alu_opcode),
    .alu_input1       (alu_input1),
    .alu_input2       (alu_input2),
    .alu_shiftValue   (alu_shiftValue),
    .alu_result       (alu_result),
    .alu_carryFlag    (alu_carryFlag),
    .alu_zeroFlag     (alu_zeroFlag),
    .alu_overFlowFlag (alu_overFlowFlag),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_result       (rsp_result),
    .rsp_carry        (rsp_carry),
    .rsp_zero         (rsp_zero),
    .rsp_overflow     (rsp_overflow),
    .rsp_illegal      (rsp_illegal),
    .rsp_tag          (rsp_tag),
    .busy             (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Returns {carry, overflow, result}.
  function automatic logic [9:0] alu_core(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic [4:0] sh);
    int s;
    logic [7:0] r;
    logic c, v;
    s = int'(sh) % 8;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd0: begin r = (a << s) | (a >> (8 - s)); c = r[0]; end
      4'd1: begin r = (a >> s) | (a << (8 - s)); c = r[7]; end
      4'd2: r = (a > b) ? a : b;
      4'd3: r = (a < b) ? a : b;
      4'd4: begin r = ($signed(a) > $signed(b)) ? 8'd1 : 8'd0; v = a[7] ^ b[7]; end
      default: r = 8'd0;
    endcase
    return {c, v, r};
  endfunction

  logic [7:0] core_r;
  always_comb begin
    {alu_carryFlag, alu_overFlowFlag, core_r} = alu_core(alu_opcode, alu_input1, alu_input2,
                                                          alu_shiftValue);
    alu_result   = core_r ^ noise;
    alu_zeroFlag = (alu_result == 8'd0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] sh;
    logic [3:0] tag;
    bit         legal;
    int         acc;
    int         start;
    int         rise;
  } req_t;

  req_t       mq[$];
  int         free_c = 0;
  logic [7:0] noise_hist [int];
  logic [3:0] m_op = '0;
  logic [7:0] m_a = '0, m_b = '0;
  logic [4:0] m_sh = '0;

  function automatic logic [4:0] norm_sh(input logic [3:0] op, input logic [4:0] sh);
    return (op <= 4'd1) ? 5'(int'(sh) % 8) : sh;
  endfunction

  // The engine takes the head once it is buffered and the previous one has drained.
  task automatic schedule();
    mq[0].start = (mq[0].acc + 1 > free_c) ? mq[0].acc + 1 : free_c;
    mq[0].rise  = mq[0].start + (mq[0].legal ? 1 + int'(LAT) : 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_op = '0; m_a = '0; m_b = '0; m_sh = '0;
    end else begin
      int in_fifo;
      bit ev;
      logic [9:0] core;
      logic [7:0] er;
      noise_hist[cyc] = noise;
      if (mq.size() > 0 && mq[0].legal && cyc > mq[0].start) begin
        m_op = mq[0].op; m_a = mq[0].a; m_b = mq[0].b; m_sh = norm_sh(mq[0].op, mq[0].sh);
      end
      chk("alu_opcode", alu_opcode, m_op);
      chk("alu_input1", alu_input1, m_a);
      chk("alu_input2", alu_input2, m_b);
      chk("alu_shiftValue", alu_shiftValue, m_sh);
      in_fifo = mq.size() - ((mq.size() > 0 && cyc > mq[0].start) ? 1 : 0);
      chk("req_ready", req_ready, in_fifo < 4);
      chk("busy", busy, mq.size() > 0);
      ev = (mq.size() > 0) && (cyc >= mq[0].rise);
      chk("rsp_valid", rsp_valid, ev);
      if (ev && rsp_valid) begin
        chk("rsp_tag", rsp_tag, mq[0].tag);
        chk("rsp_illegal", rsp_illegal, !mq[0].legal);
        if (mq[0].legal) begin
          core = alu_core(mq[0].op, mq[0].a, mq[0].b, norm_sh(mq[0].op, mq[0].sh));
          er = core[7:0] ^ noise_hist[mq[0].rise - 1];
          chk("rsp_result", rsp_result, er);
          chk("rsp_flags", {rsp_carry, rsp_overflow, rsp_zero}, {core[9], core[8], er == 8'd0});
        end else begin
          chk("rsp_result_ill", rsp_result, 8'd0);
          chk("rsp_flags_ill", {rsp_carry, rsp_overflow, rsp_zero}, 3'b000);
        end
      end
      if (ev && rsp_valid && rsp_ready) begin
        void'(mq.pop_front());
        free_c = cyc + 1;
        if (mq.size() > 0) schedule();
      end
      if (req_valid && req_ready) begin
        req_t e;
        e.op = req_opcode; e.a = req_input1; e.b = req_input2; e.sh = req_shift;
        e.tag = req_tag; e.legal = (req_opcode < 4'd5); e.acc = cyc;
        e.start = 0; e.rise = 0;
        mq.push_back(e);
        if (mq.size() == 1) schedule();
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a rising edge; leaves req_valid high on return.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [4:0] sh, input logic [3:0] tg, output int acc);
    req_opcode = op; req_input1 = a; req_input2 = b; req_shift = sh; req_tag = tg;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) timeout("send");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout("wait_rsp");
  endtask

  task automatic wait_idle();
    int done = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (done == 0) timeout("wait_idle");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, at, nt, stale;
    bit drop;

    #2 rst_n = 1'b0;
    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_req_ready", req_ready, 1'b1);
    chk("reset_alu_opcode", alu_opcode, 4'd0);
    chk("reset_rsp_result", rsp_result, 8'd0);
    chk("reset_rsp_tag", rsp_tag, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // ROL 0x81 by 1
    send(4'd0, 8'h81, 8'h00, 5'd1, 4'd3, acc);
    req_valid = 1'b0;
    wait_rsp(at);
    chk("rol_latency", at - acc, 2 + LAT);
    chk("rol_result", rsp_result, 8'h03);
    chk("rol_tag", rsp_tag, 4'd3);
    wait_idle();

    // ROR 0x01 by 9 -> shift normalised to 1
    send(4'd1, 8'h01, 8'h00, 5'd9, 4'd1, acc);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("ror_shiftValue", alu_shiftValue, 5'd1);
    wait_rsp(at);
    chk("ror_result", rsp_result, 8'h80);
    wait_idle();

    send(4'd2, 8'h10, 8'h20, 5'd0, 4'd2, acc);
    req_valid = 1'b0;
    wait_rsp(at);
    chk("max_result", rsp_result, 8'h20);
    wait_idle();

    send(4'd3, 8'h00, 8'h05, 5'd0, 4'd4, acc);
    req_valid = 1'b0;
    wait_rsp(at);
    chk("min_result", rsp_result, 8'h00);
    chk("min_zero", rsp_zero, 1'b1);
    wait_idle();

    // Illegal opcode: fast response, ALU drive untouched
    send(4'd9, 8'hAB, 8'hCD, 5'd3, 4'd7, acc);
    req_valid = 1'b0;
    wait_rsp(at);
    chk("ill_latency", at - acc, 2);
    chk("ill_flag", rsp_illegal, 1'b1);
    chk("ill_result", rsp_result, 8'h00);
    chk("ill_tag", rsp_tag, 4'd7);
    chk("ill_alu_opcode", alu_opcode, 4'd3);
    chk("ill_alu_input2", alu_input2, 8'h05);
    wait_idle();

    // ALU output wobbles during the wait; only the last wait cycle is captured
    send(4'd2, 8'h10, 8'h20, 5'd0, 4'd2, acc);
    req_valid = 1'b0;
    noise = 8'hAA;
    @(posedge clk); #1 noise = 8'hFF;
    @(posedge clk); #1 noise = 8'h0F;
    @(posedge clk); #1 noise = 8'h01;
    @(posedge clk); #1 noise = 8'h00;
    wait_rsp(at);
    chk("settle_latency", at - acc, 2 + LAT);
    chk("settle_result", rsp_result, 8'h21);
    wait_idle();

    // Back-pressure: one request held in the engine, four buffered, sixth refused
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      int a0;
      send(4'd2, 8'(i), 8'h40, 5'd0, 4'(i), a0);
      if (i == 0) acc = a0;
      chk("bp_accept_cycle", a0 - acc, i);
    end
    req_tag = 4'd5; req_input1 = 8'h05;
    @(negedge clk);
    chk("bp_sixth_refused", req_ready, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    nt = 0;
    drop = 1'b0;
    for (int k = 0; k < 200 && nt < 6; k++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        chk("bp_order_tag", rsp_tag, 4'(nt));
        nt++;
      end
      drop = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (drop) req_valid = 1'b0;
    end
    chk("bp_drain_count", nt, 6);
    req_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a wait with two requests still buffered
    send(4'd2, 8'h01, 8'h02, 5'd0, 4'd8, acc);
    send(4'd3, 8'h03, 8'h04, 5'd0, 4'd9, acc);
    send(4'd0, 8'h05, 8'h06, 5'd2, 4'd10, acc);
    req_valid = 1'b0;
    chk("pre_reset_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", rsp_valid, 1'b0);
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_alu_opcode", alu_opcode, 4'd0);
    chk("mid_reset_alu_input1", alu_input1, 8'd0);
    chk("mid_reset_rsp_tag", rsp_tag, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    stale = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid || busy) stale++;
    end
    chk("no_stale_after_reset", stale, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
